adc_scan_scheduler: RTL and testbench
=====================================

# adc_scan_scheduler

Sequences the successive-approximation ADC search engine across multiple analog inputs. It round-robins over enabled channels and drives the analog mux select. For each channel it waits a programmable settling time, restarts the search engine, and collects the 8-bit result. It then presents that result to the downstream consumer over a valid/ready handshake.

## Interface
- NUM_CH, 4, number of analog channels, legal 2..8
- SETTLE_CYCLES, 8, mux settling wait in clk cycles, legal 1..255
- TIMEOUT_CYCLES, 32, max CONVERT cycles before abort, legal 10..255

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  scanning permitted while high
- ch_mask  in  NUM_CH  per-channel enable; bit i=1 scans channel i
- mux_sel  out  3  analog mux select, current channel index
- sar_start  out  1  one-cycle restart pulse to search engine (bounds reinitialised)
- sar_done  in  1  search engine converged, valid with sar_result
- sar_result  in  8  converged code
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  result code
- res_ch  out  3  channel of res_data
- err_clr  in  1  clears timeout_err
- timeout_err  out  1  sticky, a conversion exceeded TIMEOUT_CYCLES

## Operation
- FSM states and transitions:
  - IDLE: go to SELECT when enable=1 and ch_mask!=0.
  - SELECT: pick the next set mask bit strictly after the channel pointer, wrapping at NUM_CH-1→0. Load the pointer and mux_sel, then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to CONVERT.
  - CONVERT: on sar_done, capture and go to OUTPUT. On timeout, go to NEXT.
  - OUTPUT: hold res_valid until res_ready, then go to NEXT.
  - NEXT: go to SELECT if enable=1 and ch_mask!=0, else IDLE.
- Channel pointer resets to NUM_CH-1, so the first scan starts at the lowest enabled channel.
- ch_mask is sampled only in SELECT and NEXT. Mask changes mid-conversion do not abort the conversion.
- If only one channel is enabled, it is reconverted repeatedly, including SETTLE each time.
- When enable drops mid-scan, the current conversion and handshake complete, then the FSM goes to IDLE.
- sar_done outside CONVERT is ignored.
- sar_done in the sar_start cycle is ignored. This covers the stale done left from the previous search.
- Timeout: CONVERT lasting TIMEOUT_CYCLES cycles without sar_done sets timeout_err. The channel produces no result.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, the set wins.

## Timing
- Reset values: state IDLE, mux_sel 0, sar_start 0, res_valid 0, res_data 0, res_ch 0, timeout_err 0.
- SELECT is 1 cycle. mux_sel takes its new value on the SELECT→SETTLE edge.
- SETTLE lasts exactly SETTLE_CYCLES cycles.
- sar_start is high during the first CONVERT cycle only.
- Result capture: the edge where sar_done=1 in CONVERT registers res_data/res_ch. res_valid=1 from the next cycle.
- Minimum per-channel latency, SELECT to res_valid: 1 + SETTLE_CYCLES + (cycles to sar_done) + 1.
- Handshake rules:
  - res_data and res_ch are stable while res_valid=1.
  - Transfer occurs when res_valid and res_ready are both high on a rising edge.
  - res_valid deasserts on the following cycle.
  - res_ready is allowed high before res_valid.
- With res_ready tied high, SELECT for the next channel begins 2 cycles after res_valid rises (OUTPUT, NEXT).
- Async rst mid-operation returns all outputs to reset values immediately. The pending result is discarded.

## Configuration
- ADC_SCAN_AVG_EN defined:
  - Each channel is converted 4 times back-to-back. Settling happens only before the first conversion.
  - sar_start is re-pulsed in the cycle after each sar_done.
  - Codes accumulate in a 10-bit unsigned sum; res_data = sum[9:2], truncating.
  - A timeout on any of the 4 conversions aborts the channel and sets timeout_err.
  - The TIMEOUT_CYCLES count restarts with each conversion.
- ADC_SCAN_AVG_EN undefined: a single conversion per channel. No accumulator is instantiated.

## Test plan
- Basic scan:
  - Stimulus: NUM_CH=4, SETTLE_CYCLES=8, ch_mask=4'b1011, enable=1, res_ready=1; engine model returns 8'h40+channel after 9 cycles.
  - Required: results in channel order 0,1,3,0 with codes 8'h40, 8'h41, 8'h43, 8'h40; channel 2 never selected; sar_start one cycle wide per conversion.
- Backpressure:
  - Stimulus: res_ready=0 for 20 cycles after res_valid.
  - Required: res_valid, res_data and res_ch are held constant for all 20 cycles; mux_sel is unchanged until transfer.
- Timeout:
  - Stimulus: engine never asserts sar_done on channel 1.
  - Required: timeout_err=1 after 32 CONVERT cycles; no result emitted for channel 1; scan continues on channel 3. Asserting err_clr for one cycle clears timeout_err.
- Enable/mask edges:
  - Stimulus: ch_mask=0 with enable=1.
  - Required: the FSM stays IDLE and sar_start is never asserted.
  - Stimulus: drop enable during SETTLE.
  - Required: that channel's result is still delivered, then the FSM goes to IDLE.
- Reset mid-conversion:
  - Stimulus: assert rst during CONVERT, then release it.
  - Required: all outputs return to reset values without waiting for a clock edge; the next scan starts at channel 0.
- Averaging (ADC_SCAN_AVG_EN defined):
  - Stimulus: engine returns 8'd10, 8'd11, 8'd12, 8'd14 for one channel.
  - Required: a single result res_data=8'd11 (sum 47, truncated); SETTLE occurs once; 4 sar_start pulses.

Source files
------------

// File: rtl/adc_scan_if.sv
// Bundle of the scheduler's control, SAR-engine and result-handshake signals.
// The master modport is the scheduler side; the slave modport is the surrounding system side.
interface adc_scan_if #(
    parameter int NUM_CH = 4
);
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [2:0]        mux_sel;
    logic              sar_start;
    logic              sar_done;
    logic [7:0]        sar_result;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic [2:0]        res_ch;
    logic              err_clr;
    logic              timeout_err;

    modport master (
        input  enable, ch_mask, sar_done, sar_result, res_ready, err_clr,
        output mux_sel, sar_start, res_valid, res_data, res_ch, timeout_err
    );

    modport slave (
        output enable, ch_mask, sar_done, sar_result, res_ready, err_clr,
        input  mux_sel, sar_start, res_valid, res_data, res_ch, timeout_err
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC scan scheduler: mux select, settle wait, SAR restart, result handshake.
// Define ADC_SCAN_AVG_EN to average four back-to-back conversions per channel.
module adc_scan_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    adc_scan_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_CONVERT, S_OUTPUT, S_NEXT
    } state_t;

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] PTR_INIT     = 3'(NUM_CH - 1);

    state_t     state_reg;
    logic [2:0] ptr_reg;
    logic [7:0] settle_cnt_reg;
    logic [7:0] conv_cnt_reg;
    logic [2:0] mux_sel_reg;
    logic       sar_start_reg;
    logic       res_valid_reg;
    logic [7:0] res_data_reg;
    logic [2:0] res_ch_reg;
    logic       timeout_err_reg;
`ifdef ADC_SCAN_AVG_EN
    logic [9:0] acc_reg;
    logic [1:0] avg_idx_reg;
    logic [9:0] acc_next;
    assign acc_next = acc_reg + {2'b00, bus.sar_result};
`endif

    logic [7:0] mask_wide;
    logic [2:0] cand [NUM_CH];
    logic [2:0] chan_next;
    logic       chan_found;
    logic       scan_go;
    logic       done_ok;

    assign mask_wide = 8'(bus.ch_mask);
    assign scan_go   = bus.enable && (|bus.ch_mask);
    // A done seen while the restart pulse is still high is the previous search's leftover.
    assign done_ok   = bus.sar_done && !sar_start_reg;

    // cand[gi] is the channel gi+1 positions after the pointer, wrapped at NUM_CH.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum      = {1'b0, ptr_reg} + 4'(gi + 1);
            assign cand[gi] = (sum >= 4'(NUM_CH)) ? 3'(sum - 4'(NUM_CH)) : sum[2:0];
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest enabled channel wins.
    always_comb begin
        chan_next  = ptr_reg;
        chan_found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_wide[cand[k]]) begin
                chan_next  = cand[k];
                chan_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            ptr_reg         <= PTR_INIT;
            settle_cnt_reg  <= '0;
            conv_cnt_reg    <= '0;
            mux_sel_reg     <= '0;
            sar_start_reg   <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            res_ch_reg      <= '0;
            timeout_err_reg <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_reg         <= '0;
            avg_idx_reg     <= '0;
`endif
        end else begin
            sar_start_reg <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (bus.err_clr)
                timeout_err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (scan_go)
                        state_reg <= S_SELECT;
                end
                S_SELECT: begin
                    if (chan_found) begin
                        ptr_reg        <= chan_next;
                        mux_sel_reg    <= chan_next;
                        settle_cnt_reg <= '0;
                        state_reg      <= S_SETTLE;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        sar_start_reg <= 1'b1;
                        conv_cnt_reg  <= '0;
`ifdef ADC_SCAN_AVG_EN
                        acc_reg       <= '0;
                        avg_idx_reg   <= '0;
`endif
                        state_reg     <= S_CONVERT;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 8'd1;
                    end
                end
                S_CONVERT: begin
                    if (done_ok) begin
`ifdef ADC_SCAN_AVG_EN
                        if (avg_idx_reg == 2'd3) begin
                            res_data_reg  <= acc_next[9:2];
                            res_ch_reg    <= ptr_reg;
                            res_valid_reg <= 1'b1;
                            state_reg     <= S_OUTPUT;
                        end else begin
                            acc_reg       <= acc_next;
                            avg_idx_reg   <= avg_idx_reg + 2'd1;
                            sar_start_reg <= 1'b1;
                            conv_cnt_reg  <= '0;
                        end
`else
                        res_data_reg  <= bus.sar_result;
                        res_ch_reg    <= ptr_reg;
                        res_valid_reg <= 1'b1;
                        state_reg     <= S_OUTPUT;
`endif
                    end else if (conv_cnt_reg == TIMEOUT_LAST) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= S_NEXT;
                    end else begin
                        conv_cnt_reg <= conv_cnt_reg + 8'd1;
                    end
                end
                S_OUTPUT: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    state_reg <= scan_go ? S_SELECT : S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.mux_sel     = mux_sel_reg;
    assign bus.sar_start   = sar_start_reg;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_data    = res_data_reg;
    assign bus.res_ch      = res_ch_reg;
    assign bus.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: an engine model feeds codes and predicts results,
// a monitor pops predictions on every handshake transfer.
module tb_adc_scan_scheduler;
    localparam int NUM_CH = 4;
    localparam int SETTLE = 8;
    localparam int TMO    = 32;
`ifdef ADC_SCAN_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_scan_if #(.NUM_CH(NUM_CH)) ifc();

    adc_scan_scheduler #(
        .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    res_t       exp_q[$];
    logic [2:0] got_ch[$];
    logic [7:0] got_data[$];

    // Test configuration written by the main sequence only.
    int code_mode  = 0;  // 0: 0x40+channel, 1: random, 2: averaging sequence
    int fixed_lat  = 9;  // 0 selects a random latency
    int dead_mask  = 0;  // channels whose engine never converges
    bit garbage_en = 0;

    // Engine/model state written by the engine process only.
    int starts = 0, xfers = 0, ch1_results = 0, dead_start_cyc = -1;
    int model_last = NUM_CH - 1;
    int conv_idx = 0, cur_ch = 0, acc = 0, code = 0, lat_cnt = 0;
    bit pending = 0, cur_dead = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int model_next(input int last, input logic [NUM_CH-1:0] m);
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (last + k) % NUM_CH;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic int avg_code(input int idx);
        case (idx)
            0: return 10;
            1: return 11;
            2: return 12;
            default: return 14;
        endcase
    endfunction

    // SAR engine model plus channel-order reference model.
    initial begin
        ifc.sar_done   = 1'b0;
        ifc.sar_result = 8'h00;
        forever begin
            @(negedge clk);
            ifc.sar_done = 1'b0;
            if (rst) begin
                pending    = 0;
                conv_idx   = 0;
                acc        = 0;
                model_last = NUM_CH - 1;
                continue;
            end
            if (pending) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    pending        = 0;
                    ifc.sar_done   = 1'b1;
                    ifc.sar_result = 8'(code);
                    acc += code;
                    conv_idx++;
                    if (conv_idx == NCONV) begin
                        exp_q.push_back('{ch: 3'(cur_ch), data: 8'(acc / NCONV)});
                        conv_idx = 0;
                    end
                end
            end else if (garbage_en && ifc.res_valid && $urandom_range(3) == 0) begin
                ifc.sar_done   = 1'b1;
                ifc.sar_result = 8'($urandom);
            end
            if (ifc.sar_start) begin
                starts++;
                if (conv_idx == 0) begin
                    cur_ch = model_next(model_last, ifc.ch_mask);
                    check("mux_sel_order", int'(ifc.mux_sel), cur_ch);
                    model_last = cur_ch;
                    acc        = 0;
                    cur_dead   = dead_mask[cur_ch];
                end
                if (cur_dead) begin
                    dead_start_cyc = cyc;
                    conv_idx       = 0;
                end else begin
                    pending = 1;
                    lat_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 20));
                    case (code_mode)
                        0:       code = 'h40 + cur_ch;
                        1:       code = int'($urandom_range(0, 255));
                        default: code = avg_code(conv_idx);
                    endcase
                    // Stale done during the restart cycle must be ignored.
                    if (garbage_en && $urandom_range(1) == 1) begin
                        ifc.sar_done   = 1'b1;
                        ifc.sar_result = ~8'(code);
                    end
                end
            end
        end
    end

    // Monitor: handshake rules and scoreboard pops.
    initial begin
        bit         prev_valid = 0, prev_xfer = 0, prev_start = 0, xfer;
        logic [7:0] prev_data = '0;
        logic [2:0] prev_ch = '0;
        res_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0; prev_xfer = 0; prev_start = 0;
                continue;
            end
            if (prev_xfer) begin
                check("valid_drop", int'(ifc.res_valid), 0);
            end else if (prev_valid) begin
                check("hold_valid", int'(ifc.res_valid), 1);
                check("hold_data", int'(ifc.res_data), int'(prev_data));
                check("hold_ch", int'(ifc.res_ch), int'(prev_ch));
            end
            if (ifc.sar_start) check("start_width", int'(prev_start), 0);
            xfer = ifc.res_valid && ifc.res_ready;
            if (xfer) begin
                xfers++;
                if (ifc.res_ch == 3'd1) ch1_results++;
                got_ch.push_back(ifc.res_ch);
                got_data.push_back(ifc.res_data);
                check("result_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("res_ch", int'(ifc.res_ch), int'(e.ch));
                    check("res_data", int'(ifc.res_data), int'(e.data));
                end
            end
            prev_valid = ifc.res_valid;
            prev_data  = ifc.res_data;
            prev_ch    = ifc.res_ch;
            prev_xfer  = xfer;
            prev_start = ifc.sar_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ifc.enable    = 1'b0;
        ifc.res_ready = 1'b1;
        repeat (300) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux_sel"}, int'(ifc.mux_sel), 0);
        check({tag, "_sar_start"}, int'(ifc.sar_start), 0);
        check({tag, "_res_valid"}, int'(ifc.res_valid), 0);
        check({tag, "_res_data"}, int'(ifc.res_data), 0);
        check({tag, "_res_ch"}, int'(ifc.res_ch), 0);
        check({tag, "_timeout_err"}, int'(ifc.timeout_err), 0);
    endtask

    initial begin
        int s0, x0, n, base;
        logic [7:0] hd;
        logic [2:0] hc, hm;
        rst = 1'b1;
        ifc.enable = 1'b0; ifc.ch_mask = '0; ifc.res_ready = 1'b1; ifc.err_clr = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Empty mask: nothing may start.
        ifc.enable = 1'b1;
        repeat (40) tick();
        check("mask0_starts", starts, 0);
        check("mask0_valid", int'(ifc.res_valid), 0);
        ifc.enable = 1'b0;

        // Basic scan over mask 1011.
        ifc.ch_mask = 4'b1011;
        ifc.enable  = 1'b1;
        for (int i = 0; i < 1000 && xfers < 4; i++) tick();
        check("basic_count", int'(xfers >= 4), 1);
        drain();
        if (got_ch.size() >= 4) begin
            check("basic_ch0", int'(got_ch[0]), 0);
            check("basic_ch1", int'(got_ch[1]), 1);
            check("basic_ch2", int'(got_ch[2]), 3);
            check("basic_ch3", int'(got_ch[3]), 0);
            check("basic_d0", int'(got_data[0]), 'h40);
            check("basic_d2", int'(got_data[2]), 'h43);
        end

        // Backpressure: hold for 20 cycles.
        ifc.res_ready = 1'b0;
        ifc.enable    = 1'b1;
        for (int i = 0; i < 300 && !ifc.res_valid; i++) tick();
        check("bp_valid_seen", int'(ifc.res_valid), 1);
        hd = ifc.res_data; hc = ifc.res_ch; hm = ifc.mux_sel;
        repeat (20) begin
            tick();
            check("bp_valid", int'(ifc.res_valid), 1);
            check("bp_data", int'(ifc.res_data), int'(hd));
            check("bp_ch", int'(ifc.res_ch), int'(hc));
            check("bp_mux", int'(ifc.mux_sel), int'(hm));
        end
        ifc.res_ready = 1'b1;
        drain();

        // Timeout on channel 1.
        dead_mask = 2;
        n = ch1_results;
        ifc.enable = 1'b1;
        for (int i = 0; i < 600 && !ifc.timeout_err; i++) tick();
        check("timeout_set", int'(ifc.timeout_err), 1);
        check("timeout_len", cyc - dead_start_cyc, TMO);
        s0 = starts;
        for (int i = 0; i < 100 && starts == s0; i++) tick();
        check("after_timeout_mux", int'(ifc.mux_sel), 3);
        drain();
        check("timeout_no_ch1", ch1_results, n);
        check("timeout_sticky", int'(ifc.timeout_err), 1);
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
        check("err_clr", int'(ifc.timeout_err), 0);
        dead_mask = 0;

        // Drop enable during SETTLE: that channel still completes.
        ifc.enable = 1'b1;
        x0 = xfers;
        for (int i = 0; i < 300 && xfers == x0; i++) tick();
        check("en_drop_first", int'(xfers > x0), 1);
        repeat (3) tick();
        ifc.enable = 1'b0;
        s0 = starts; x0 = xfers;
        repeat (300) tick();
        check("en_drop_starts", starts, s0 + 1);
        check("en_drop_xfers", xfers, x0 + 1);
        check("en_drop_idle", int'(ifc.res_valid), 0);

        // Asynchronous reset during CONVERT.
        ifc.enable = 1'b1;
        for (int i = 0; i < 300 && !ifc.sar_start; i++) tick();
        check("rst_conv_seen", int'(ifc.sar_start), 1);
        tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        s0 = starts;
        for (int i = 0; i < 100 && starts == s0; i++) tick();
        check("post_rst_ch0", int'(ifc.mux_sel), 0);
        drain();

        // Randomized scans with backpressure, stale dones and occasional dead channels.
        code_mode = 1; fixed_lat = 0; garbage_en = 1;
        for (int it = 0; it < 6; it++) begin
            ifc.ch_mask = 4'($urandom_range(1, 15));
            dead_mask   = ($urandom_range(3) == 0) ? (1 << $urandom_range(0, NUM_CH - 1)) : 0;
            ifc.enable  = 1'b1;
            repeat (400) begin
                ifc.res_ready = ($urandom_range(2) != 0);
                tick();
            end
            drain();
        end
        dead_mask = 0; garbage_en = 0;

`ifdef ADC_SCAN_AVG_EN
        // Averaging: 10, 11, 12, 14 -> 47 >> 2 = 11.
        code_mode = 2; fixed_lat = 5;
        ifc.ch_mask = 4'b0001;
        s0 = starts; x0 = xfers; base = cyc;
        ifc.enable = 1'b1;
        for (int i = 0; i < 500 && xfers == x0; i++) tick();
        ifc.enable = 1'b0;
        repeat (5) tick();
        check("avg_xfers", xfers, x0 + 1);
        check("avg_starts", starts, s0 + 4);
        check("avg_data", int'(got_data[got_data.size() - 1]), 11);
        check("avg_one_settle", int'(cyc - base < 2 + SETTLE + 4 * 7 + 10), 1);
        drain();
`else
        base = cyc;
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
